// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, idle line level and default frame shape.
// Used by the transmit framer and intended for reuse by a matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL    = 1'b1;
  localparam int   UART_DATA_BITS_DEF = 8;
  localparam int   UART_STOP_BITS_DEF = 1;

endpackage

// File: rtl/baud_edge_detect.sv
// Turns the divider's baud square wave into a one-cycle strobe on each rising edge.
// The registered copy clears on reset, so a high baud_in right after reset yields one tick.
module baud_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_in,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge clk) begin
    if (!rst_n) baud_q <= 1'b0;
    else        baud_q <= baud_in;
  end

  assign tick = baud_in & ~baud_q;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: valid/ready byte in, LSB-first frame on tx, bit boundaries on baud ticks.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF,
  parameter int STOP_BITS = UART_STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 tick;
  logic                 accept;

  baud_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud_in (baud_in),
    .tick    (tick)
  );

  assign tx_ready = (state == ST_IDLE) & rst_n;
  assign busy     = (state != ST_IDLE);
  assign accept   = tx_valid & tx_ready;

`ifdef UART_TX_PARITY_EN
  logic par;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  // Payload path: captured on accept, shifted one place per data-bit tick.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh <= tx_data;
`ifdef UART_TX_PARITY_EN
      par <= even_parity(tx_data);
`endif
    end else if (tick && state == ST_DATA && bit_cnt != LAST_BIT) begin
      sh <= sh >> 1;
    end
  end

  // Frame sequencer: every transition except the accept waits for a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx       <= UART_IDLE_LEVEL;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (accept) state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= sh[0];
            bit_cnt <= 3'd0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= ST_PARITY;
`else
              tx    <= UART_IDLE_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              tx      <= sh[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx    <= UART_IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) state <= ST_IDLE;
            else                       stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= UART_IDLE_LEVEL;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: one-stop and two-stop instances share clock and baud.
// Follows UART_TX_PARITY_EN so expected frames include the parity bit when it is defined.
module tb_uart_tx_framer;

  localparam int BAUD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif
  localparam int N1 = 10 + PAR_ON;
  localparam int N2 = 11 + PAR_ON;

  logic       clk, rst_n, baud_in;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2, tx, tx2, busy, busy2;

  int checks = 0, failures = 0;
  int acc1 = 0, acc2 = 0;
  int bcnt;

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_in(baud_in), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_in = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      bcnt = (bcnt + 1) % BAUD;
      baud_in = (bcnt < BAUD / 2);
    end
  end

  // Count handshakes just before the clock edge that takes them.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (tx_valid && tx_ready) acc1++;
      if (tx_valid2 && tx_ready2) acc2++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int which);
    return (which != 0) ? tx2 : tx;
  endfunction

  // Expected frame, bit 0 = start bit; p is the hand-computed even parity bit.
  function automatic logic [15:0] fr(input logic [7:0] d, input logic p, input int stops);
    logic [15:0] f;
    int pos;
    f = {7'b0, d, 1'b0};
    pos = 9;
    if (PAR_ON != 0) begin
      f[pos] = p;
      pos++;
    end
    for (int s = 0; s < stops; s++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic send(input int which, input logic [7:0] d);
    int k;
    k = 0;
    if (which != 0) begin
      tx_data2 = d;
      tx_valid2 = 1'b1;
      while (!tx_ready2 && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
      tx_valid2 = 1'b0;
    end else begin
      tx_data = d;
      tx_valid = 1'b1;
      while (!tx_ready && k < 1000) begin @(negedge clk); k++; end
      @(negedge clk);
      tx_valid = 1'b0;
    end
    chk("send_ready_wait", (k < 1000), 1'b1);
  endtask

  // Samples each bit at its first, middle and last cycle; returns at the last cycle of the frame.
  task automatic rx_frame(input int which, input int n, output logic [15:0] bits,
                          output int wait_cyc, output bit edges_ok);
    logic s0, s15;
    bits = '0;
    edges_ok = 1'b1;
    wait_cyc = 0;
    while (line(which) !== 1'b0 && wait_cyc < 4 * BAUD) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (line(which) !== 1'b0) begin
      edges_ok = 1'b0;
      bits = '1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      s0 = line(which);
      repeat (BAUD / 2) @(negedge clk);
      bits[i] = line(which);
      repeat (BAUD / 2 - 1) @(negedge clk);
      s15 = line(which);
      if (s0 !== bits[i] || s15 !== bits[i]) edges_ok = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] b1, b2;
    int w1, w2, a, k, lows;
    bit e1, e2;

    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_valid2 = 1'b0;
    tx_data = 8'h00;
    tx_data2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", tx_ready, 1'b0);
    chk("reset_tx2", tx2, 1'b1);
    chk("reset_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", tx_ready, 1'b1);
    chk("release_busy", busy, 1'b0);

    // 0x55, one stop bit
    a = acc1;
    send(0, 8'h55);
    rx_frame(0, N1, b1, w1, e1);
    chk("frame_55", b1, fr(8'h55, 1'b0, 1));
    chk("bitlen_55", e1, 1'b1);
    chk("busy_in_stop", busy, 1'b1);
    @(negedge clk);
    chk("busy_after_55", busy, 1'b0);
    chk("ready_after_55", tx_ready, 1'b1);
    chk("accepts_55", acc1 - a, 1);

    // 0x07: parity bit 1 when enabled
    send(0, 8'h07);
    rx_frame(0, N1, b1, w1, e1);
    chk("frame_07", b1, fr(8'h07, 1'b1, 1));
    chk("bitlen_07", e1, 1'b1);
    @(negedge clk);

    // 0xA3 on the two-stop instance
    send(1, 8'hA3);
    rx_frame(1, N2, b1, w1, e1);
    chk("frame_a3_2stop", b1, fr(8'hA3, 1'b0, 2));
    chk("bitlen_a3", e1, 1'b1);
    chk("ready2_in_stop2", tx_ready2, 1'b0);
    @(negedge clk);
    chk("ready2_after", tx_ready2, 1'b1);
    chk("busy2_after", busy2, 1'b0);

    // Back-to-back 0x01 then 0x80 with tx_valid held
    a = acc1;
    tx_data = 8'h01;
    tx_valid = 1'b1;
    fork
      begin
        rx_frame(0, N1, b1, w1, e1);
        rx_frame(0, N1, b2, w2, e2);
      end
      begin
        k = 0;
        while (acc1 < a + 1 && k < 1000) begin @(negedge clk); k++; end
        tx_data = 8'h80;
        while (acc1 < a + 2 && k < 2000) begin @(negedge clk); k++; end
        tx_valid = 1'b0;
      end
    join
    chk("frame_b2b_01", b1, fr(8'h01, 1'b1, 1));
    chk("frame_b2b_80", b2, fr(8'h80, 1'b1, 1));
    chk("bitlen_b2b", e1 & e2, 1'b1);
    chk("gap_b2b", (w2 <= BAUD + 1) && (w2 > 0), 1'b1);
    chk("accepts_b2b", acc1 - a, 2);
    @(negedge clk);

    // tx_data churn and tx_valid toggling while busy
    a = acc1;
    send(0, 8'h3C);
    fork
      rx_frame(0, N1, b1, w1, e1);
      begin
        repeat (40) begin
          @(negedge clk);
          tx_valid = ~tx_valid;
          tx_data = 8'($urandom);
        end
        tx_valid = 1'b0;
      end
    join
    chk("frame_3c_churn", b1, fr(8'h3C, 1'b0, 1));
    chk("accepts_churn", acc1 - a, 1);
    @(negedge clk);

    // Reset in the middle of a frame
    send(0, 8'hF0);
    repeat (30) @(negedge clk);
    chk("midframe_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tx", tx, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_ready", tx_ready, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrelease_ready", tx_ready, 1'b1);
    lows = 0;
    repeat (5 * BAUD) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_retransmit", lows, 0);
    chk("idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
